// File: rtl/fast_updown_counter_if.sv
// ============================================================================
// Module  : fast_updown_counter_if
// Purpose : Request/result bundle between a counter client and the counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fast_updown_counter_if #(
  parameter int WIDTH = 32
) ();
  logic             inc;
  logic             dec;
  logic             set;
  logic [WIDTH-1:0] set_val;
  logic [WIDTH-1:0] q;
  logic             q_is_zero;

  modport master (
    output inc, dec, set, set_val,
    input  q, q_is_zero
  );

  modport slave (
    input  inc, dec, set, set_val,
    output q, q_is_zero
  );
endinterface

`default_nettype wire

// File: rtl/fast_counter_step.sv
// ============================================================================
// Module  : fast_counter_step
// Purpose : Produces up_val+1 and dn_val-1 with a zero flag for each result.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fast_counter_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] up_val,
  input  wire logic [WIDTH-1:0] dn_val,
  output logic      [WIDTH-1:0] plus,
  output logic      [WIDTH-1:0] minus,
  output logic                  plus_zero,
  output logic                  minus_zero
);
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Zero flags come from comparing the inputs, not the adder outputs.
  always_comb begin
    plus       = up_val + C_ONE;
    minus      = dn_val - C_ONE;
    plus_zero  = &up_val;
    minus_zero = (dn_val == C_ONE);
  end
endmodule

`default_nettype wire

// File: rtl/fast_updown_counter.sv
// ============================================================================
// Module  : fast_updown_counter
// Purpose : Up/down counter with load; q+1/q-1 are held ready in registers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fast_updown_counter #(
  parameter int WIDTH = 32
) (
  input  wire logic              clk,
  input  wire logic              nrst,
  fast_updown_counter_if.slave   bus
);
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_up;
  logic [WIDTH-1:0] r_q_dn;
  logic             r_q_zero;
  logic             r_up_zero;
  logic             r_dn_zero;

  logic [WIDTH-1:0] w_set_up;
  logic [WIDTH-1:0] w_set_dn;
  logic             w_set_up_zero;
  logic             w_set_dn_zero;
  logic             w_set_zero;
  logic [WIDTH-1:0] w_run_up;
  logic [WIDTH-1:0] w_run_dn;
  logic             w_run_up_zero;
  logic             w_run_dn_zero;
  logic             w_do_inc;
  logic             w_do_dec;

  fast_counter_step #(.WIDTH(WIDTH)) u_step_set (
    .up_val     (bus.set_val),
    .dn_val     (bus.set_val),
    .plus       (w_set_up),
    .minus      (w_set_dn),
    .plus_zero  (w_set_up_zero),
    .minus_zero (w_set_dn_zero)
  );

  // Running path: the next neighbours are one step beyond the current ones.
  fast_counter_step #(.WIDTH(WIDTH)) u_step_run (
    .up_val     (r_q_up),
    .dn_val     (r_q_dn),
    .plus       (w_run_up),
    .minus      (w_run_dn),
    .plus_zero  (w_run_up_zero),
    .minus_zero (w_run_dn_zero)
  );

  always_comb begin
    w_set_zero = (bus.set_val == '0);
    w_do_inc   = bus.inc & ~bus.dec;
    w_do_dec   = bus.dec & ~bus.inc;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_q       <= '0;
      r_q_up    <= C_ONE;
      r_q_dn    <= '1;
      r_q_zero  <= 1'b1;
      r_up_zero <= 1'b0;
      r_dn_zero <= 1'b0;
    end else if (bus.set) begin
      r_q       <= bus.set_val;
      r_q_up    <= w_set_up;
      r_q_dn    <= w_set_dn;
      r_q_zero  <= w_set_zero;
      r_up_zero <= w_set_up_zero;
      r_dn_zero <= w_set_dn_zero;
    end else if (w_do_inc) begin
      // Shift the window up: old q becomes the down neighbour.
      r_q       <= r_q_up;
      r_q_zero  <= r_up_zero;
      r_q_up    <= w_run_up;
      r_up_zero <= w_run_up_zero;
      r_q_dn    <= r_q;
      r_dn_zero <= r_q_zero;
    end else if (w_do_dec) begin
      r_q       <= r_q_dn;
      r_q_zero  <= r_dn_zero;
      r_q_dn    <= w_run_dn;
      r_dn_zero <= w_run_dn_zero;
      r_q_up    <= r_q;
      r_up_zero <= r_q_zero;
    end
  end

  assign bus.q         = r_q;
  assign bus.q_is_zero = r_q_zero;
endmodule

`default_nettype wire

// File: tb/tb_fast_updown_counter.sv
// ============================================================================
// Module  : tb_fast_updown_counter
// Purpose : Randomised and directed checks of fast_updown_counter (WIDTH=14).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fast_updown_counter;
  localparam int W = 14;
  localparam int M = 1 << W;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  fast_updown_counter_if #(.WIDTH(W)) bus ();

  fast_updown_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;
  int exp_q  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: plain modular arithmetic on an integer.
  always @(posedge clk or negedge nrst) begin
    if (!nrst)                       exp_q <= 0;
    else if (bus.set)                exp_q <= int'(bus.set_val);
    else if (bus.inc && !bus.dec)    exp_q <= (exp_q + 1) % M;
    else if (bus.dec && !bus.inc)    exp_q <= (exp_q + M - 1) % M;
  end

  always @(negedge clk) begin
    if (cmp_en && nrst) begin
      chk("model_q",    int'(bus.q),         exp_q);
      chk("model_zero", int'(bus.q_is_zero), int'(exp_q == 0));
    end
  end

  task automatic cyc(input bit s, input bit i, input bit d, input int v);
    bus.set     = s;
    bus.inc     = i;
    bus.dec     = d;
    bus.set_val = W'(v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input int q_exp, input int z_exp);
    chk({nm, "_q"},    int'(bus.q),         q_exp);
    chk({nm, "_zero"}, int'(bus.q_is_zero), z_exp);
  endtask

  int prev;
  int v;

  initial begin
    bus.set = 0; bus.inc = 0; bus.dec = 0; bus.set_val = '0;

    // Asynchronous reset between edges
    #2 nrst = 1'b0;
    #1 lit("reset_async", 0, 1);
    @(negedge clk);
    nrst   = 1'b1;
    cmp_en = 1'b1;
    repeat (3) begin
      cyc(0, 0, 0, 0);
      lit("reset_idle", 0, 1);
    end

    // Load then count down
    cyc(1, 0, 0, 'h1234);
    lit("load_1234", 'h1234, 0);
    for (int k = 1; k <= 20; k++) begin
      prev = int'(bus.q);
      cyc(0, 0, 1, 0);
      chk("dec_step", (int'(bus.q) + 1) % M, prev);
      chk("dec_val",  int'(bus.q), 'h1234 - k);
    end

    // Increment across the top
    cyc(1, 0, 0, 'h3FFE);
    cyc(0, 1, 0, 0); lit("inc_3fff", 'h3FFF, 0);
    cyc(0, 1, 0, 0); lit("inc_wrap", 'h0000, 1);
    cyc(0, 1, 0, 0); lit("inc_0001", 'h0001, 0);

    // Decrement across zero, then load zero
    cyc(1, 0, 0, 'h0001);
    cyc(0, 0, 1, 0); lit("dec_zero", 'h0000, 1);
    cyc(0, 0, 1, 0); lit("dec_wrap", 'h3FFF, 0);
    cyc(1, 0, 0, 0); lit("load_zero", 'h0000, 1);

    // Priority
    cyc(1, 1, 1, 'h0ABC); lit("set_wins", 'h0ABC, 0);
    cyc(0, 1, 1, 0);      lit("both_hold", 'h0ABC, 0);
    cyc(0, 0, 0, 0);      lit("idle_hold", 'h0ABC, 0);

    // Random traffic with boundary-biased load values
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 4))
        0:       v = 0;
        1:       v = 1;
        2:       v = M - 1;
        3:       v = M - 2;
        default: v = int'($urandom_range(0, M - 1));
      endcase
      cyc($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, v);
    end

    // Reset in the middle of counting
    cyc(1, 0, 0, 'h2000);
    repeat (50) cyc(0, 0, 1, 0);
    lit("dec50", 'h2000 - 50, 0);
    bus.set = 0; bus.inc = 0; bus.dec = 0;
    #1 nrst = 1'b0;
    #1 lit("reset_mid", 0, 1);
    #4 nrst = 1'b1;
    @(negedge clk);
    lit("reset_post", 0, 1);
    cyc(0, 0, 1, 0);
    lit("reset_dec", 'h3FFF, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fast_updown_counter.md
Name: fast_updown_counter

Overview:
- Registered up/down counter with synchronous load, built for high clock rates (200 MHz class) at wide widths.
- Next-value candidates (q+1, q-1) and their zero flags are precomputed in registers, so the per-cycle update is only a 3:1 mux with no adder in the q feedback path.
- Used as a general-purpose event counter and down-counter/timer: load with `set`, count with `inc`/`dec`, watch `q_is_zero`.

Parameters:
- WIDTH, 32, counter width in bits (>=2); the bench instantiates 14.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nrst  input  1  asynchronous active-low reset.
- inc  input  1  increment request, sampled on the clk rising edge.
- dec  input  1  decrement request, sampled on the clk rising edge.
- set  input  1  synchronous load request.
- set_val  input  WIDTH  value loaded when set=1.
- q  output  WIDTH  counter value, driven directly from a register.
- q_is_zero  output  1  high exactly when q==0, driven from a register.

Behaviour:
- Reset (nrst=0, asynchronous, independent of clk):
  - q=0, q_is_zero=1.
  - Internal precompute registers reset to q_up=1, q_dn=all-ones, with matching zero flags.
  - Deassertion takes effect at the next rising edge.
- Priority each rising edge: set > (inc XOR dec) > hold.
  - set=1: q<=set_val, regardless of inc/dec.
  - inc=1, dec=0: q<=q+1.
  - dec=1, inc=0: q<=q-1.
  - inc=dec=1, or all requests low: q holds.
- Latency: one cycle. A request sampled at edge N appears on q after edge N. Back-to-back requests give one step per cycle, no bubbles.
- Arithmetic: modulo 2^WIDTH, unsigned, no saturation.
  - Wraps 2^WIDTH-1 -> 0 on inc and 0 -> 2^WIDTH-1 on dec.
  - No overflow/underflow flag.
- Invariant at every clock edge and after reset: q_is_zero == (q==0), including the cycle after a load of 0 and after wrap-around.
- Implementation requirement:
  - Hold registers q, q_up (=q+1), q_dn (=q-1) plus zero flags for each.
  - On inc: new q_up=q_up+1, new q_dn=q.
  - On dec: new q_dn=q_dn-1, new q_up=q.
  - On set: q_up=set_val+1, q_dn=set_val-1; the zero flag is computed from set_val.
  - All adder inputs come directly from registers or ports.
- Reset mid-operation: the counter clears immediately; pending requests are discarded.
- No X on outputs after reset for any input pattern.

Decomposition:
- No shared package needed; WIDTH is the only configuration.
- One natural sub-module, fast_counter_step: takes a WIDTH-bit value and returns value+1 and value-1 plus a zero flag for each. It is instantiated for the set_val path and the running path.

Test Plan (WIDTH=14):
- Reset: assert nrst=0 between clock edges -> q=0x0000 and q_is_zero=1 immediately. Release, idle 3 cycles -> unchanged.
- Load then count down: set=1, set_val=0x1234 for one cycle -> q=0x1234 next cycle. Hold dec=1 -> q=0x1233, 0x1232, ..., one per cycle. Check q_prev==q+1 every cycle.
- Count up with wrap: set_val=0x3FFE, then inc=1 -> q=0x3FFF, 0x0000 (q_is_zero=1), 0x0001 (q_is_zero=0).
- Dec wrap and zero flag: set_val=0x0001, dec=1 -> q=0x0000 (q_is_zero=1), then 0x3FFF (q_is_zero=0). Load 0x0000 -> q_is_zero=1 the next cycle.
- Priority:
  - set=1, inc=1, dec=1, set_val=0x0ABC -> q=0x0ABC.
  - inc=dec=1 without set -> q holds 0x0ABC.
  - Random inc/dec/set/set_val for 10k cycles against a reference model -> exact q and q_is_zero match.
- Reset mid-count: run dec from 0x2000 for 50 cycles, pulse nrst low for 5 ns -> q=0 at once. After release, dec=1 -> 0x3FFF.
